// File: rtl/flags_unit.sv
// ---------------------------------------------------------------------------
// flags_unit
//
// This block holds the processor condition flags {C,N,Z}. The flags are
// updated by masked ALU writes, by the set-carry and clear-carry commands,
// and by clears on taken conditional jumps. It also evaluates conditional
// jumps and keeps a two-entry save stack for interrupt entry and RTI.
//
// Ports
//   clk          : clock; all state changes on the rising edge
//   rst_n        : asynchronous, active-low reset
//   alu_flags    : ALU flags_out {rsvd,C,N,Z}; bit3 is ignored
//   flags_we     : the current instruction writes flags
//   flags_mask   : per-flag write enable {C,N,Z}, gated by flags_we
//   setc / clrc  : set / clear carry (clrc wins when both are set)
//   jmp_eval     : a jump is evaluated this cycle
//   jmp_cond     : 00 always, 01 JZ, 10 JN, 11 JC
//   int_save     : push flags on interrupt entry
//   rti_restore  : pop flags on return from interrupt
//   stall        : freeze all state; branch_taken is 0 on the next cycle
//   flags        : registered flags {0,C,N,Z}
//   branch_taken : registered one-cycle pulse for a taken jump
//   depth        : save-stack occupancy, 0..2
//   err          : sticky overflow/underflow/conflict error
// ---------------------------------------------------------------------------
module flags_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] alu_flags,
  input  logic       flags_we,
  input  logic [2:0] flags_mask,
  input  logic       setc,
  input  logic       clrc,
  input  logic       jmp_eval,
  input  logic [1:0] jmp_cond,
  input  logic       int_save,
  input  logic       rti_restore,
  input  logic       stall,
  output logic [3:0] flags,
  output logic       branch_taken,
  output logic [1:0] depth,
  output logic       err
);

  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_Z      = 2'b01;
  localparam logic [1:0] COND_N      = 2'b10;
  localparam logic [1:0] COND_C      = 2'b11;

  // State: only three flag bits are stored, because bit3 is always 0.
  logic [2:0] flag_bits;
  logic [2:0] stack_mem [2];
  logic [1:0] depth_cnt;
  logic       err_flag;
  logic       taken_pulse;

  logic [2:0] flag_bits_next;
  logic [2:0] stack_next [2];
  logic [1:0] depth_next;
  logic       err_next;
  logic       taken_next;

  // Intermediate update stages. Each stage builds on the previous one, so a
  // later stage wins per bit.
  logic       cond_true;
  logic       jump_taken;
  logic [2:0] write_mask;
  logic [2:0] after_alu;
  logic [2:0] after_carry;
  logic [2:0] after_jump;
  logic [2:0] stack_top;

  // The reserved ALU bit is not used in this block.
  logic unused_alu_bit;
  assign unused_alu_bit = alu_flags[3];

  // The jump condition is tested on the registered flags, not on this
  // cycle's update.
  always_comb begin
    cond_true = 1'b0;
    unique case (jmp_cond)
      COND_ALWAYS: cond_true = 1'b1;
      COND_Z:      cond_true = flag_bits[0];
      COND_N:      cond_true = flag_bits[1];
      COND_C:      cond_true = flag_bits[2];
      default:     cond_true = 1'b0;
    endcase
  end

  assign jump_taken = jmp_eval & cond_true & ~stall;

  // Stage 1: masked ALU write.
  assign write_mask = flags_we ? flags_mask : 3'b000;
  assign after_alu  = (flag_bits & ~write_mask) | (alu_flags[2:0] & write_mask);

  // Stage 2: carry commands. clrc wins over setc.
  always_comb begin
    after_carry = after_alu;
    if (clrc) begin
      after_carry[2] = 1'b0;
    end else if (setc) begin
      after_carry[2] = 1'b1;
    end
  end

  // Stage 3: a taken conditional jump clears the flag it tested.
  // An unconditional jump clears nothing.
  always_comb begin
    after_jump = after_carry;
    if (jump_taken) begin
      unique case (jmp_cond)
        COND_Z:  after_jump[0] = 1'b0;
        COND_N:  after_jump[1] = 1'b0;
        COND_C:  after_jump[2] = 1'b0;
        default: after_jump    = after_carry;
      endcase
    end
  end

  // Top of the LIFO. Entry 0 is the bottom and entry 1 is the top when full.
  assign stack_top = (depth_cnt == 2'd2) ? stack_mem[1] : stack_mem[0];

  // Stack, flags and error sequencing.
  always_comb begin
    flag_bits_next = flag_bits;
    stack_next[0]  = stack_mem[0];
    stack_next[1]  = stack_mem[1];
    depth_next     = depth_cnt;
    err_next       = err_flag;
    taken_next     = jump_taken;

    if (!stall) begin
      if (rti_restore) begin
        // Restore takes priority. All other flag updates this cycle are
        // dropped. A save in the same cycle is a conflict.
        if (int_save) begin
          err_next = 1'b1;
        end
        if (depth_cnt != 2'd0) begin
          flag_bits_next = stack_top;
          depth_next     = depth_cnt - 2'd1;
        end else begin
          err_next = 1'b1;
        end
      end else begin
        flag_bits_next = after_jump;
        if (int_save) begin
          // Push the pre-update flags. A push onto a full stack is dropped.
          if (depth_cnt == 2'd2) begin
            err_next = 1'b1;
          end else begin
            stack_next[depth_cnt[0]] = flag_bits;
            depth_next               = depth_cnt + 2'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_bits    <= 3'b000;
      stack_mem[0] <= 3'b000;
      stack_mem[1] <= 3'b000;
      depth_cnt    <= 2'd0;
      err_flag     <= 1'b0;
      taken_pulse  <= 1'b0;
    end else begin
      flag_bits    <= flag_bits_next;
      stack_mem[0] <= stack_next[0];
      stack_mem[1] <= stack_next[1];
      depth_cnt    <= depth_next;
      err_flag     <= err_next;
      taken_pulse  <= taken_next;
    end
  end

  assign flags        = {1'b0, flag_bits};
  assign branch_taken = taken_pulse;
  assign depth        = depth_cnt;
  assign err          = err_flag;

endmodule

// File: doc/flags_unit.md
FLAGS_UNIT -- requirements
Module: flags_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port alu_flags, input, 4 bits: ALU flags_out; bit0 Z, bit1 N, bit2 C, bit3 reserved.
REQ-004 SHALL have port flags_we, input, 1 bit: the current instruction writes flags.
REQ-005 SHALL have port flags_mask, input, 3 bits: per-flag write enable for {C,N,Z}, qualified by flags_we.
REQ-006 SHALL have port setc, input, 1 bit: set C.
REQ-007 SHALL have port clrc, input, 1 bit: clear C.
REQ-008 SHALL have port jmp_eval, input, 1 bit: a conditional jump is evaluated this cycle.
REQ-009 SHALL have port jmp_cond, input, 2 bits: 00 unconditional, 01 JZ, 10 JN, 11 JC.
REQ-010 SHALL have port int_save, input, 1 bit: push flags on interrupt entry.
REQ-011 SHALL have port rti_restore, input, 1 bit: pop flags on RTI.
REQ-012 SHALL have port stall, input, 1 bit: freeze the unit.
REQ-013 SHALL have port flags, output, 4 bits: registered flags, fed back to ALU flags_in.
REQ-014 SHALL have port branch_taken, output, 1 bit: registered one-cycle pulse.
REQ-015 SHALL have port depth, output, 2 bits: save-stack occupancy, 0..2.
REQ-016 SHALL have port err, output, 1 bit: sticky overflow/underflow/conflict error.

Function
REQ-017 SHALL keep flags[3] at 0 at all times; writes to bit3 are ignored.
REQ-018 SHALL evaluate jumps on the registered flags value (pre-update); condition 00 is always true.
REQ-019 SHALL pulse branch_taken high for exactly one cycle following a cycle with jmp_eval=1, a true condition and stall=0; otherwise branch_taken SHALL be 0.
REQ-020 SHALL clear the tested flag (Z, N or C) on a taken conditional jump; an unconditional jump clears nothing.
REQ-021 SHALL apply non-stack updates in this order within one cycle: ALU masked write, then setc/clrc, then taken-jump clear (the last applied wins per bit).
REQ-022 SHALL treat setc and clrc asserted together as clrc.
REQ-023 SHALL implement a 2-entry LIFO save stack; int_save pushes the registered flags value, and flags are otherwise updated normally that cycle.
REQ-024 SHALL, on rti_restore with depth>0, load flags from the top entry and decrement depth; all other flag updates that cycle are discarded, and branch_taken still follows REQ-019.
REQ-025 SHALL, on int_save with depth=2, drop the push, keep depth=2 and set err.
REQ-026 SHALL, on rti_restore with depth=0, leave flags unchanged, keep depth=0 and set err.
REQ-027 SHALL, when int_save and rti_restore are asserted together, perform only the restore (REQ-024/026) and set err.
REQ-028 SHALL, while stall=1, hold flags, stack, depth and err, and drive branch_taken 0 the next cycle.
REQ-029 SHALL clear err only by reset.

Reset
REQ-030 SHALL, while rst_n=0, force flags=0000, branch_taken=0, depth=0, err=0 and clear both stack entries, regardless of clk.
REQ-031 SHALL resume normal operation on the first rising clk edge after rst_n deasserts; a reset mid-jump suppresses any pending branch_taken pulse.

Verification
REQ-032 SHALL verify masked write: flags=0000; flags_we=1, mask=111, alu_flags=0110 -> flags=0110; then mask=001, alu_flags=0001 -> flags=0111.
REQ-033 SHALL verify taken JC: flags=0100; jmp_eval=1, cond=11 -> branch_taken=1 for one cycle, flags=0000; repeating the jump -> branch_taken=0.
REQ-034 SHALL verify jump/ALU collision: flags=0001; jmp_eval=1, cond=01 with flags_we=1, mask=001, alu_flags=0001 -> branch_taken=1, flags Z=0.
REQ-035 SHALL verify the stack: flags=0010 push, flags=0101 push, push again -> depth=2 and err=1; pop -> flags=0101; pop -> flags=0010; pop -> depth=0, flags=0010.
REQ-036 SHALL verify stall: stall=1 with setc and jmp_eval cond=00 -> flags unchanged and branch_taken=0.
REQ-037 SHALL verify async reset: assert rst_n=0 mid-cycle with depth=1, err=1 -> all outputs zero immediately, without a clk edge.
